// File: rtl/pong_pkg.sv
// Shared Pong constants and types: screen geometry, coordinate width and
// the game-state enumeration. The graphics stage uses the same constants.
package pong_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int H_CENTRE = SCREEN_W / 2;
    localparam int V_CENTRE = SCREEN_H / 2;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        POINT,
        GAME_OVER
    } state_t;

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: two-flop synchronisers on the raw up/down buttons, then a
// per-frame step of PADDLE_SPEED clamped to the visible screen height.
// Pressing both buttons or neither leaves the paddle where it is.
module pong_paddle_ctrl
    import pong_pkg::*;
#(
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_SPEED = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_enable,
    input  logic               i_up,
    input  logic               i_down,
    output logic [COORD_W-1:0] o_y
);

    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(SCREEN_H - PADDLE_H);
    localparam logic [COORD_W-1:0] Y_RESET = COORD_W'(V_CENTRE - PADDLE_H / 2);
    localparam logic [COORD_W-1:0] STEP    = COORD_W'(PADDLE_SPEED);

    logic               r_upMeta;
    logic               r_upSync;
    logic               r_downMeta;
    logic               r_downSync;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] w_yNext;

    // Bring the asynchronous buttons into the clock domain
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_upMeta   <= 1'b0;
            r_upSync   <= 1'b0;
            r_downMeta <= 1'b0;
            r_downSync <= 1'b0;
        end else begin
            r_upMeta   <= i_up;
            r_upSync   <= r_upMeta;
            r_downMeta <= i_down;
            r_downSync <= r_downMeta;
        end
    end

    // Next paddle position: one step per frame, saturating at top and bottom
    always_comb begin
        w_yNext = r_y;
        if (i_tick && i_enable) begin
            if (r_upSync && !r_downSync) begin
                w_yNext = (r_y >= STEP) ? (r_y - STEP) : '0;
            end else if (r_downSync && !r_upSync) begin
                w_yNext = (r_y >= (Y_MAX - STEP)) ? Y_MAX : (r_y + STEP);
            end
        end
    end

    // Paddle position register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_y <= Y_RESET;
        end else begin
            r_y <= w_yNext;
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/pong_game_logic.sv
// Pong game-state engine: ball motion, wall and paddle collisions, scoring
// and the serve / point / game-over sequence, advanced once per video frame
// on the rising edge of endofframe.
// Optional build macro PONG_SPEEDUP_EN: each paddle hit speeds the ball up
// by one pixel per frame, up to twice the base speed, until the next serve.
module pong_game_logic
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_SPEED = 4,
    parameter int PADDLE_ONE_X = 16,
    parameter int PADDLE_TWO_X = 616,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic               clk50M,
    input  logic               reset,
    input  logic               endofframe,
    input  logic               p1_up,
    input  logic               p1_down,
    input  logic               p2_up,
    input  logic               p2_down,
    input  logic               start,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] paddle_one_x,
    output logic [COORD_W-1:0] paddle_one_y,
    output logic [COORD_W-1:0] paddle_two_x,
    output logic [COORD_W-1:0] paddle_two_y,
    output logic [3:0]         score_one,
    output logic [3:0]         score_two,
    output logic               game_over
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [COORD_W-1:0] BALL_CX = COORD_W'(H_CENTRE - BALL_SIZE / 2);
    localparam logic [COORD_W-1:0] BALL_CY = COORD_W'(V_CENTRE - BALL_SIZE / 2);
    localparam logic [3:0]         WIN     = 4'(WIN_SCORE);

    // Ball limits in the signed 11-bit domain the next position lives in
    localparam logic signed [COORD_W:0] S_ZERO     = '0;
    localparam logic signed [COORD_W:0] X_MAX      = (COORD_W+1)'(SCREEN_W - BALL_SIZE);
    localparam logic signed [COORD_W:0] Y_MAX      = (COORD_W+1)'(SCREEN_H - BALL_SIZE);
    localparam logic signed [COORD_W:0] LEFT_FACE  = (COORD_W+1)'(PADDLE_ONE_X + PADDLE_W);
    localparam logic signed [COORD_W:0] RIGHT_STOP = (COORD_W+1)'(PADDLE_TWO_X - BALL_SIZE);

    state_t                    r_state;
    state_t                    w_stateNext;
    logic                      r_eofQ;
    logic                      w_tick;
    logic                      r_startMeta;
    logic                      r_startSync;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cntNext;
    logic [COORD_W-1:0]        r_ballX;
    logic [COORD_W-1:0]        r_ballY;
    logic [COORD_W-1:0]        w_ballXNext;
    logic [COORD_W-1:0]        w_ballYNext;
    logic                      r_dxNeg;
    logic                      r_dyNeg;
    logic                      w_dxNegNext;
    logic                      w_dyNegNext;
    logic [3:0]                r_scoreOne;
    logic [3:0]                r_scoreTwo;
    logic [3:0]                w_scoreOneNext;
    logic [3:0]                w_scoreTwoNext;
    logic                      r_gameOver;
    logic [3:0]                w_step;
    logic signed [COORD_W:0]   w_stepS;
    logic signed [COORD_W:0]   w_nx;
    logic signed [COORD_W:0]   w_ny;
    logic [COORD_W-1:0]        w_paddleOneY;
    logic [COORD_W-1:0]        w_paddleTwoY;
    logic                      w_paddleEnable;
    logic                      w_overlapOne;
    logic                      w_overlapTwo;

    // Frame tick from the rising edge of endofframe, and start synchroniser
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            r_eofQ      <= 1'b0;
            r_startMeta <= 1'b0;
            r_startSync <= 1'b0;
        end else begin
            r_eofQ      <= endofframe;
            r_startMeta <= start;
            r_startSync <= r_startMeta;
        end
    end

    assign w_tick         = endofframe & ~r_eofQ;
    assign w_paddleEnable = (r_state != GAME_OVER);

    pong_paddle_ctrl #(
        .PADDLE_H     (PADDLE_H),
        .PADDLE_SPEED (PADDLE_SPEED)
    ) u_paddleOne (
        .i_clk    (clk50M),
        .i_reset  (reset),
        .i_tick   (w_tick),
        .i_enable (w_paddleEnable),
        .i_up     (p1_up),
        .i_down   (p1_down),
        .o_y      (w_paddleOneY)
    );

    pong_paddle_ctrl #(
        .PADDLE_H     (PADDLE_H),
        .PADDLE_SPEED (PADDLE_SPEED)
    ) u_paddleTwo (
        .i_clk    (clk50M),
        .i_reset  (reset),
        .i_tick   (w_tick),
        .i_enable (w_paddleEnable),
        .i_up     (p2_up),
        .i_down   (p2_down),
        .o_y      (w_paddleTwoY)
    );

`ifdef PONG_SPEEDUP_EN
    logic [3:0] r_step;
    logic [3:0] w_stepNext;

    // Ball speed: one faster per paddle hit, back to base whenever a serve begins
    always_comb begin
        w_stepNext = r_step;
        if (w_tick && (w_stateNext == SERVE) && (r_state != SERVE)) begin
            w_stepNext = 4'(BALL_SPEED);
        end else if (w_tick && (r_state == PLAY) && (w_dxNegNext != r_dxNeg)
                     && (r_step < 4'(2 * BALL_SPEED))) begin
            w_stepNext = r_step + 4'd1;
        end
    end

    // Ball speed register
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            r_step <= 4'(BALL_SPEED);
        end else begin
            r_step <= w_stepNext;
        end
    end

    assign w_step = r_step;
`else
    assign w_step = 4'(BALL_SPEED);
`endif

    // Candidate next position, signed so a step past zero cannot wrap
    assign w_stepS = $signed({{(COORD_W-3){1'b0}}, w_step});
    assign w_nx = r_dxNeg ? ($signed({1'b0, r_ballX}) - w_stepS)
                          : ($signed({1'b0, r_ballX}) + w_stepS);
    assign w_ny = r_dyNeg ? ($signed({1'b0, r_ballY}) - w_stepS)
                          : ($signed({1'b0, r_ballY}) + w_stepS);

    // Vertical overlap is judged on the ball's current row against each paddle
    assign w_overlapOne = (({1'b0, r_ballY} + (COORD_W+1)'(BALL_SIZE)) > {1'b0, w_paddleOneY})
                       && ({1'b0, r_ballY} < ({1'b0, w_paddleOneY} + (COORD_W+1)'(PADDLE_H)));
    assign w_overlapTwo = (({1'b0, r_ballY} + (COORD_W+1)'(BALL_SIZE)) > {1'b0, w_paddleTwoY})
                       && ({1'b0, r_ballY} < ({1'b0, w_paddleTwoY} + (COORD_W+1)'(PADDLE_H)));

    // Game sequencing and ball physics, evaluated once per frame tick.
    // During a point the ball direction is left alone: it still points at
    // the player who missed, so the next serve heads toward that player.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_ballXNext    = r_ballX;
        w_ballYNext    = r_ballY;
        w_dxNegNext    = r_dxNeg;
        w_dyNegNext    = r_dyNeg;
        w_scoreOneNext = r_scoreOne;
        w_scoreTwoNext = r_scoreTwo;
        if (w_tick) begin
            unique case (r_state)
                SERVE: begin
                    w_ballXNext = BALL_CX;
                    w_ballYNext = BALL_CY;
                    w_cntNext   = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                        w_stateNext = PLAY;
                    end
                end
                PLAY: begin
                    if (w_ny <= S_ZERO) begin
                        w_ballYNext = '0;
                        w_dyNegNext = ~r_dyNeg;
                    end else if (w_ny >= Y_MAX) begin
                        w_ballYNext = Y_MAX[COORD_W-1:0];
                        w_dyNegNext = ~r_dyNeg;
                    end else begin
                        w_ballYNext = w_ny[COORD_W-1:0];
                    end
                    if (r_dxNeg && (w_nx <= LEFT_FACE) && w_overlapOne) begin
                        w_ballXNext = LEFT_FACE[COORD_W-1:0];
                        w_dxNegNext = 1'b0;
                    end else if (!r_dxNeg && (w_nx >= RIGHT_STOP) && w_overlapTwo) begin
                        w_ballXNext = RIGHT_STOP[COORD_W-1:0];
                        w_dxNegNext = 1'b1;
                    end else if (w_nx <= S_ZERO) begin
                        w_ballXNext    = '0;
                        w_scoreTwoNext = (r_scoreTwo < WIN) ? (r_scoreTwo + 4'd1) : r_scoreTwo;
                        w_stateNext    = POINT;
                    end else if (w_nx >= X_MAX) begin
                        w_ballXNext    = X_MAX[COORD_W-1:0];
                        w_scoreOneNext = (r_scoreOne < WIN) ? (r_scoreOne + 4'd1) : r_scoreOne;
                        w_stateNext    = POINT;
                    end else begin
                        w_ballXNext = w_nx[COORD_W-1:0];
                    end
                end
                POINT: begin
                    w_ballXNext = BALL_CX;
                    w_ballYNext = BALL_CY;
                    if (r_dxNeg ? (r_scoreTwo == WIN) : (r_scoreOne == WIN)) begin
                        w_stateNext = GAME_OVER;
                    end else begin
                        w_cntNext   = '0;
                        w_stateNext = SERVE;
                    end
                end
                GAME_OVER: begin
                    w_ballXNext = BALL_CX;
                    w_ballYNext = BALL_CY;
                    if (r_startSync) begin
                        w_scoreOneNext = '0;
                        w_scoreTwoNext = '0;
                        w_dxNegNext    = 1'b0;
                        w_dyNegNext    = 1'b0;
                        w_cntNext      = '0;
                        w_stateNext    = SERVE;
                    end
                end
            endcase
        end
    end

    // Game state, ball, direction and score registers
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            r_state    <= SERVE;
            r_cnt      <= '0;
            r_ballX    <= BALL_CX;
            r_ballY    <= BALL_CY;
            r_dxNeg    <= 1'b0;
            r_dyNeg    <= 1'b0;
            r_scoreOne <= '0;
            r_scoreTwo <= '0;
            r_gameOver <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_ballX    <= w_ballXNext;
            r_ballY    <= w_ballYNext;
            r_dxNeg    <= w_dxNegNext;
            r_dyNeg    <= w_dyNegNext;
            r_scoreOne <= w_scoreOneNext;
            r_scoreTwo <= w_scoreTwoNext;
            r_gameOver <= (w_stateNext == GAME_OVER);
        end
    end

    assign ball_x       = r_ballX;
    assign ball_y       = r_ballY;
    assign paddle_one_x = COORD_W'(PADDLE_ONE_X);
    assign paddle_two_x = COORD_W'(PADDLE_TWO_X);
    assign paddle_one_y = w_paddleOneY;
    assign paddle_two_y = w_paddleTwoY;
    assign score_one    = r_scoreOne;
    assign score_two    = r_scoreTwo;
    assign game_over    = r_gameOver;

endmodule
